// File: rtl/cpu_pkg.sv
// Shared CPU types for the register-file write path.
//   regidx_t : 5-bit architectural register index
//   word_t   : 32-bit data word
//   wb_req_t : one register-file write request {wa, wd}
//   reg_mask : one-hot mask of a register index, r0 never flagged
package cpu_pkg;

    localparam int unsigned NREGS = 32;

    typedef logic [4:0]  regidx_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        regidx_t wa;
        word_t   wd;
    } wb_req_t;

    // r0 is hardwired to zero, so it never becomes pending.
    function automatic logic [NREGS-1:0] reg_mask(input regidx_t idx);
        logic [NREGS-1:0] m;
        m      = '0;
        m[idx] = (idx != '0);
        return m;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy.
// Ports:
//   clk, resetn     : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata     : write strobe and data (must not push when full)
//   pop             : read strobe, advances the head (must not pop when empty)
//   rdata           : current head, valid whenever empty is low
//   full, empty     : occupancy flags derived from the registered count
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam logic [PW:0] FullCnt = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      cnt_q, cnt_d;

    assign full  = (cnt_q == FullCnt);
    assign empty = (cnt_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!resetn) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!resetn) !(pop && empty));

endmodule

// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter between pipeline writeback and the mul/div unit.
// The pipeline has priority; MDU results wait in a FIFO and are forced through once
// the head has waited STARVE_LIMIT cycles. A pending-write scoreboard of MDU
// destinations lets decode detect RAW/WAW hazards.
// Ports:
//   clk, resetn                : clock, asynchronous active-low reset
//   pipe_we/pipe_wa/pipe_wd    : pipeline writeback request
//   wb_stall                   : pipeline must hold its writeback this cycle
//   mdu_valid/mdu_wa/mdu_wd    : MDU result, accepted when mdu_ready
//   mdu_ready                  : result FIFO not full
//   issue_valid/issue_wa       : MDU op issued, marks its destination pending
//   ra1, ra2 -> busy1, busy2   : decode read indices and their pending status
//   issue_busy                 : issue_wa already has a pending MDU write
//   write_enable/wa3/wd3       : register-file write port
module regwrite_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_wa,
    input  logic [31:0] pipe_wd,
    output logic        wb_stall,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_wa,
    input  logic [31:0] mdu_wd,
    input  logic        issue_valid,
    input  logic [4:0]  issue_wa,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        busy1,
    output logic        busy2,
    output logic        issue_busy,
    output logic        write_enable,
    output logic [4:0]  wa3,
    output logic [31:0] wd3
);

    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

    wb_req_t push_req;
    wb_req_t head;
    wb_req_t grant;
    logic    grant_valid;
    logic    fifo_push;
    logic    fifo_pop;
    logic    fifo_full;
    logic    fifo_empty;
    logic    force_mdu;

    logic [SW-1:0]    starve_q, starve_d;
    logic [NREGS-1:0] pend_q, pend_d;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    // ---------------------------------------------------------------- MDU buffer
    assign push_req  = '{wa: regidx_t'(mdu_wa), wd: word_t'(mdu_wd)};
    assign mdu_ready = !fifo_full;
    assign fifo_push = mdu_valid && !fifo_full;

    sync_fifo #(
        .WIDTH ($bits(wb_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_mdu_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .wdata  (push_req),
        .pop    (fifo_pop),
        .rdata  (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // ---------------------------------------------------------------- arbitration
    assign force_mdu = !fifo_empty && (starve_q == StarveMax);

    always_comb begin
        fifo_pop    = 1'b0;
        wb_stall    = 1'b0;
        grant_valid = 1'b0;
        grant       = '0;
        if (force_mdu) begin
            // Pipeline loses the slot and replays the same write next cycle.
            fifo_pop    = 1'b1;
            grant       = head;
            grant_valid = 1'b1;
            wb_stall    = pipe_we;
        end else if (pipe_we) begin
            grant       = '{wa: regidx_t'(pipe_wa), wd: word_t'(pipe_wd)};
            grant_valid = 1'b1;
        end else if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            grant       = head;
            grant_valid = 1'b1;
        end
    end

    // Writes to r0 still consume the grant (and the FIFO entry) but never reach the file.
    assign write_enable = resetn && grant_valid && (grant.wa != '0);
    assign wa3          = grant.wa;
    assign wd3          = grant.wd;

    // ---------------------------------------------------------------- starvation
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || fifo_pop) begin
            starve_d = '0;
        end else if (starve_q != StarveMax) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------- scoreboard
    // The clear lands at the edge that commits the value, so busy falls exactly when
    // the register file can supply the new data. A same-cycle re-issue must win.
    always_comb begin
        set_mask = issue_valid ? reg_mask(regidx_t'(issue_wa)) : '0;
        clr_mask = fifo_pop ? reg_mask(head.wa) : '0;
        pend_d   = (pend_q & ~clr_mask) | set_mask;
    end

    assign busy1      = pend_q[ra1];
    assign busy2      = pend_q[ra2];
    assign issue_busy = pend_q[issue_wa];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_q <= '0;
            pend_q   <= '0;
        end else begin
            starve_q <= starve_d;
            pend_q   <= pend_d;
        end
    end

    // Decode may not re-issue a pending destination, except in the cycle its previous
    // result is being committed (the new pending bit then supersedes the old one).
    a_issue_not_busy: assert property (@(posedge clk) disable iff (!resetn)
        !(issue_valid && issue_busy && !(fifo_pop && head.wa == regidx_t'(issue_wa))));

endmodule
